mem_arbiter: RTL and testbench

Shares one single-port unified memory between the rv32 core's instruction-fetch port and its data port. Sequences each access through a req/ready handshake to memory and returns per-port acknowledge, read data and stall signals to the pipeline. Data accesses have priority. An optional guard bounds how long fetch can be starved. Sits between the core's fetch/data interfaces and the external memory model.

---
 rtl/rv32_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 45 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 definitions used by the memory arbiter and its starvation counter.
package rv32_pkg;

  localparam int DEFAULT_XLEN         = 32;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while fetch is waiting; raises
// forceFetch_o once the count reaches LIMIT so fetch wins the next grant.
module arb_starve_ctr
  import rv32_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic dataGrant_i,
  input  logic fetchGrant_i,
  input  logic iReq_i,
  output logic forceFetch_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A data grant with no fetch waiting means fetch was not starved, so it clears too.
  always_comb begin
    count_d = count_q;
    if (fetchGrant_i) begin
      count_d = '0;
    end else if (dataGrant_i) begin
      if (!iReq_i) begin
        count_d = '0;
      end else if (count_q != W'(LIMIT)) begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign forceFetch_o = (count_q == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the rv32 fetch and data ports onto one single-port memory, data first.
// Define ARB_STARVE_GUARD_EN to bound how many data grants fetch can lose in a row.
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            stallF,
  output logic            stallM,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ready
);

  arb_state_t      state_q, state_d;
  logic            mReq_q, mReq_d;
  logic            mWe_q, mWe_d;
  logic [XLEN-1:0] mAddr_q, mAddr_d;
  logic [XLEN-1:0] mWdata_q, mWdata_d;
  logic            iAck_q, iAck_d;
  logic            dAck_q, dAck_d;
  logic [XLEN-1:0] iRdata_q, iRdata_d;
  logic [XLEN-1:0] dRdata_q, dRdata_d;

  logic iEligible;
  logic grantI;
  logic grantD;
  logic forceFetch;

  // A port in its ack cycle cannot be re-granted, but a held d_req still blocks fetch.
  assign iEligible = i_req & ~iAck_q;
  assign grantD    = (state_q == IDLE) & d_req & ~dAck_q & ~(forceFetch & iEligible);
  assign grantI    = (state_q == IDLE) & iEligible & (~d_req | forceFetch);

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) uStarveCtr (
    .clk         (clk),
    .reset       (reset),
    .dataGrant_i (grantD),
    .fetchGrant_i(grantI),
    .iReq_i      (i_req),
    .forceFetch_o(forceFetch)
  );
`else
  logic unusedStarveLimit;
  assign unusedStarveLimit = (STARVE_LIMIT == 0);
  assign forceFetch        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mReq_d   = mReq_q;
    mWe_d    = mWe_q;
    mAddr_d  = mAddr_q;
    mWdata_d = mWdata_q;
    iAck_d   = 1'b0;
    dAck_d   = 1'b0;
    iRdata_d = iRdata_q;
    dRdata_d = dRdata_q;
    case (state_q)
      IDLE: begin
        if (grantD) begin
          state_d  = BUSY_D;
          mReq_d   = 1'b1;
          mWe_d    = d_we;
          mAddr_d  = d_addr;
          mWdata_d = d_wdata;
        end else if (grantI) begin
          state_d = BUSY_I;
          mReq_d  = 1'b1;
          mWe_d   = 1'b0;
          mAddr_d = i_addr;
        end
      end
      BUSY_I: begin
        if (m_ready) begin
          state_d  = IDLE;
          mReq_d   = 1'b0;
          iAck_d   = 1'b1;
          iRdata_d = m_rdata;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          state_d = IDLE;
          mReq_d  = 1'b0;
          dAck_d  = 1'b1;
          if (!mWe_q) begin
            dRdata_d = m_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
        mReq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mReq_q   <= 1'b0;
      mWe_q    <= 1'b0;
      mAddr_q  <= '0;
      mWdata_q <= '0;
      iAck_q   <= 1'b0;
      dAck_q   <= 1'b0;
      iRdata_q <= '0;
      dRdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mReq_q   <= mReq_d;
      mWe_q    <= mWe_d;
      mAddr_q  <= mAddr_d;
      mWdata_q <= mWdata_d;
      iAck_q   <= iAck_d;
      dAck_q   <= dAck_d;
      iRdata_q <= iRdata_d;
      dRdata_q <= dRdata_d;
    end
  end

  assign m_req   = mReq_q;
  assign m_we    = mWe_q;
  assign m_addr  = mAddr_q;
  assign m_wdata = mWdata_q;
  assign i_ack   = iAck_q;
  assign d_ack   = dAck_q;
  assign i_rdata = iRdata_q;
  assign d_rdata = dRdata_q;
  assign stallF  = i_req & ~iAck_q;
  assign stallM  = d_req & ~dAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed handshake/priority/reset cases, then randomized
// traffic against a memory model with per-port expected-response queues.
module tb_mem_arbiter;

  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            reset;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            stallF;
  logic            stallM;
  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_rdata;
  logic            m_ready;

  int total = 0;
  int bad   = 0;

  logic        reqDone;
  logic [31:0] lastLoadExp;
  logic [31:0] iExpQ[$];
  logic [31:0] dExpQ[$];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];

  mem_arbiter #(
    .XLEN        (XLEN),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_ack  (i_ack),
    .i_rdata(i_rdata),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_ack  (d_ack),
    .d_rdata(d_rdata),
    .stallF (stallF),
    .stallM (stallM),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory contents for any word never written.
  function automatic logic [31:0] romValue(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    @(negedge clk);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic fetchRequester(input int n);
    int cyc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_addr = 32'($urandom_range(0, 63)) << 2;
      i_req  = 1'b1;
      iExpQ.push_back(romValue(i_addr));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!i_ack && cyc < 400);
      checkOutput("fetch ack within bound", 32'(i_ack), 32'd1);
      i_req = 1'b0;
    end
  endtask

  task automatic dataRequester(input int n);
    int cyc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d_addr  = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      if (d_we) begin
        shadow[d_addr] = d_wdata;
      end else begin
        lastLoadExp = shadow.exists(d_addr) ? shadow[d_addr] : romValue(d_addr);
      end
      dExpQ.push_back(lastLoadExp);
      d_req = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!d_ack && cyc < 400);
      checkOutput("data ack within bound", 32'(d_ack), 32'd1);
      d_req = 1'b0;
    end
  endtask

  task automatic memoryModel();
    int lat;
    lat = int'($urandom_range(0, 2));
    do begin
      @(negedge clk);
      m_ready = 1'b0;
      if (m_req) begin
        if (lat == 0) begin
          m_ready = 1'b1;
          if (m_we) begin
            memArr[m_addr] = m_wdata;
            m_rdata = $urandom;
          end else begin
            m_rdata = memArr.exists(m_addr) ? memArr[m_addr] : romValue(m_addr);
          end
          lat = int'($urandom_range(0, 2));
        end else begin
          lat--;
        end
      end
    end while (!reqDone);
    m_ready = 1'b0;
  endtask

  task automatic scoreboardMonitor();
    logic        prevMreq;
    logic [31:0] expVal;
    prevMreq = 1'b0;
    do begin
      @(negedge clk);
      if (m_req && !prevMreq) begin
        if (m_addr >= 32'h2000) begin
          checkOutput("mem data addr", m_addr, d_addr);
          checkOutput("mem data we", 32'(m_we), 32'(d_we));
          if (d_we) checkOutput("mem data wdata", m_wdata, d_wdata);
        end else begin
          checkOutput("mem fetch addr", m_addr, i_addr);
          checkOutput("mem fetch we", 32'(m_we), 32'd0);
        end
      end
      prevMreq = m_req;
      if (i_ack) begin
        if (iExpQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL fetch ack with nothing pending: i_rdata=%h", i_rdata);
        end else begin
          expVal = iExpQ.pop_front();
          checkOutput("fetch rdata", i_rdata, expVal);
        end
      end
      if (d_ack) begin
        if (dExpQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL data ack with nothing pending: d_rdata=%h", d_rdata);
        end else begin
          expVal = dExpQ.pop_front();
          checkOutput("data rdata", d_rdata, expVal);
        end
      end
    end while (!reqDone);
  endtask

  initial begin
    int dataGrants;
    int fetchGrants;
    int dataBeforeFetch;
    int ackCount;
    int reqCount;

    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    reqDone = 1'b0;
    lastLoadExp = '0;

    #1;
    checkOutput("reset m_req", 32'(m_req), 32'd0);
    checkOutput("reset acks", {30'b0, i_ack, d_ack}, 32'd0);
    checkOutput("reset i_rdata", i_rdata, 32'd0);
    checkOutput("reset d_rdata", d_rdata, 32'd0);
    checkOutput("reset m_addr", m_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single fetch, memory answers three cycles after m_req.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch m_req", 32'(m_req), 32'd1);
    checkOutput("fetch m_addr", m_addr, 32'h100);
    checkOutput("fetch m_we", 32'(m_we), 32'd0);
    checkOutput("fetch stallF busy", 32'(stallF), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("fetch m_req held", 32'(m_req), 32'd1);
    checkOutput("fetch no early ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h00500093;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput("fetch ack", 32'(i_ack), 32'd1);
    checkOutput("fetch rdata", i_rdata, 32'h00500093);
    checkOutput("fetch m_req cleared", 32'(m_req), 32'd0);
    checkOutput("fetch stallF at ack", 32'(stallF), 32'd0);
    @(negedge clk);
    checkOutput("fetch ack one cycle", 32'(i_ack), 32'd0);
    checkOutput("fetch ack cycle no regrant", 32'(m_req), 32'd0);
    checkOutput("fetch rdata held", i_rdata, 32'h00500093);
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("fetch idle after drop", 32'(m_req), 32'd0);

    // Simultaneous store and fetch: store first, fetch in the d_ack cycle.
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("both store first m_we", 32'(m_we), 32'd1);
    checkOutput("both store m_addr", m_addr, 32'h2000);
    checkOutput("both store m_wdata", m_wdata, 32'hDEADBEEF);
    checkOutput("both stalls", {30'b0, stallF, stallM}, 32'd3);
    m_ready = 1'b1;
    m_rdata = 32'h11111111;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput("both d_ack", 32'(d_ack), 32'd1);
    checkOutput("both stalls at d_ack", {30'b0, stallF, stallM}, 32'd2);
    checkOutput("store leaves d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("fetch granted in d_ack cycle", 32'(m_req), 32'd1);
    checkOutput("fetch after store m_addr", m_addr, 32'h104);
    checkOutput("fetch after store m_we", 32'(m_we), 32'd0);
    checkOutput("fetch after store stallF", 32'(stallF), 32'd1);
    m_ready = 1'b1;
    m_rdata = 32'h00A00113;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput("second fetch ack", 32'(i_ack), 32'd1);
    checkOutput("second fetch rdata", i_rdata, 32'h00A00113);
    i_req = 1'b0;

    // m_ready while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ready = 1'b1;
      m_rdata = 32'hFFFF0000 + 32'(k);
      @(negedge clk);
      m_ready = 1'b0;
      checkOutput("idle m_ready no ack", {29'b0, m_req, i_ack, d_ack}, 32'd0);
    end
    checkOutput("idle m_ready d_rdata kept", d_rdata, 32'd0);
    checkOutput("idle m_ready i_rdata kept", i_rdata, 32'h00A00113);

    // Continuous loads with fetch waiting.
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 32'h2100, 32'h0);
    dataGrants = 0;
    fetchGrants = 0;
    dataBeforeFetch = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      m_ready = 1'b0;
      if (d_ack) d_addr = d_addr + 32'd4;
      if (m_req) begin
        m_ready = 1'b1;
        m_rdata = 32'h12340000 + 32'(c);
        if (m_addr >= 32'h2000) begin
          dataGrants++;
        end else begin
          if (fetchGrants == 0) dataBeforeFetch = dataGrants;
          fetchGrants++;
        end
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starve data grants before fetch", 32'(dataBeforeFetch), 32'(STARVE_LIMIT));
`else
    checkOutput("strict priority fetch grants", 32'(fetchGrants), 32'd0);
    checkOutput("strict priority data flowing", 32'(dataGrants >= 8), 32'd1);
`endif
    applyStimulus(1'b0, 32'h108, 1'b0, 1'b0, 32'h2100, 32'h0);
    for (int c = 0; c < 6; c++) begin
      m_ready = m_req;
      @(negedge clk);
    end
    m_ready = 1'b0;
    checkOutput("drain m_req", 32'(m_req), 32'd0);

    // Load with d_req dropped right after grant.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2010, 32'h0);
    @(negedge clk);
    checkOutput("drop load m_req", 32'(m_req), 32'd1);
    checkOutput("drop load m_addr", m_addr, 32'h2010);
    d_req = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'hCAFE0001;
    ackCount = 0;
    reqCount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_ready = 1'b0;
      if (d_ack) ackCount++;
      if (m_req) reqCount++;
    end
    checkOutput("drop load ack count", 32'(ackCount), 32'd1);
    checkOutput("drop load no second access", 32'(reqCount), 32'd0);
    checkOutput("drop load d_rdata", d_rdata, 32'hCAFE0001);
    lastLoadExp = 32'hCAFE0001;

    // Randomized traffic through the scoreboard.
    @(negedge clk);
    reqDone = 1'b0;
    fork
      begin
        fork
          fetchRequester(25);
          dataRequester(25);
        join
        reqDone = 1'b1;
      end
      memoryModel();
      scoreboardMonitor();
    join
    checkOutput("fetch queue drained", 32'(iExpQ.size()), 32'd0);
    checkOutput("data queue drained", 32'(dExpQ.size()), 32'd0);

    // Reset in the middle of a store.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2040, 32'h55AA55AA);
    @(negedge clk);
    checkOutput("busy_d before reset", 32'(m_req), 32'd1);
    #2;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("reset abort m_req", 32'(m_req), 32'd0);
    checkOutput("reset abort all outputs",
                32'(|{m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata,
                      stallF, stallM}), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    ackCount = 0;
    reqCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_ready = 1'b0;
      if (d_ack) ackCount++;
      if (m_req) reqCount++;
    end
    checkOutput("no ack after reset abort", 32'(ackCount), 32'd0);
    checkOutput("no access after reset abort", 32'(reqCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
